// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ex_stage_pkg
// Purpose : Shared opcode / result-select codes, bus widths, NOP address and
//           the execute-stage shift FSM encoding, plus small opcode decoders.
// Ports   : (package - none)
// Revision: 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

    localparam int c_ALU_OP_W  = 8;
    localparam int c_ALU_SEL_W = 3;
    localparam int c_ADDR_W    = 5;
    localparam int c_DATA_W    = 32;

    // alu_op codes
    localparam logic [7:0] c_EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] c_EXE_AND_OP = 8'b0010_0100;
    localparam logic [7:0] c_EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] c_EXE_XOR_OP = 8'b0010_0110;
    localparam logic [7:0] c_EXE_NOR_OP = 8'b0010_0111;
    localparam logic [7:0] c_EXE_SLL_OP = 8'b0111_1100;
    localparam logic [7:0] c_EXE_SRL_OP = 8'b0000_0010;
    localparam logic [7:0] c_EXE_SRA_OP = 8'b0000_0011;

    // alu_sel codes
    localparam logic [2:0] c_EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] c_EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] c_EXE_RES_SHIFT = 3'b010;

    localparam logic [4:0] c_NOP_REG_ADDR = 5'd0;

    // Shift FSM encoding
    localparam logic [1:0] c_EX_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_EX_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_EX_ST_DONE  = 2'd2;

    // Shift kinds handed to the shift unit
    localparam logic [1:0] c_SH_SLL = 2'd0;
    localparam logic [1:0] c_SH_SRL = 2'd1;
    localparam logic [1:0] c_SH_SRA = 2'd2;

    function automatic logic is_shift_op(input logic [7:0] op);
        return (op == c_EXE_SLL_OP) || (op == c_EXE_SRL_OP) || (op == c_EXE_SRA_OP);
    endfunction

    function automatic logic [1:0] shift_kind(input logic [7:0] op);
        logic [1:0] k;
        k = c_SH_SLL;
        if (op == c_EXE_SRL_OP) k = c_SH_SRL;
        if (op == c_EXE_SRA_OP) k = c_SH_SRA;
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_shift_unit.sv
`default_nettype none
// ============================================================================
// Module  : ex_shift_unit
// Purpose : Iterative shifter (SHIFT_STEP bits per cycle) with IDLE/SHIFT/DONE
//           FSM. Result is presented in DONE until retired or aborted.
// Ports   : clk, rst (sync, active-low)
//           start  - load value/amt/kind and begin shifting (amt != 0)
//           abort  - drop whatever is held, return to IDLE
//           kind   - sll / srl / sra
//           amt    - shift amount, value - operand to shift
//           busy   - shifting in progress, done - result valid, result
// Revision: 1.0 - initial release
// ============================================================================
module ex_shift_unit
    import ex_stage_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  kind,
    input  logic [4:0]  amt,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [4:0] c_STEP = 5'(SHIFT_STEP);

    logic [1:0]  r_state, w_state_nxt;
    logic [1:0]  r_kind,  w_kind_nxt;
    logic [31:0] r_acc,   w_acc_nxt;
    logic [4:0]  r_cnt,   w_cnt_nxt;
    logic [4:0]  w_step;
    logic [31:0] w_acc_shifted;

    // Final step may be shorter than SHIFT_STEP.
    always_comb begin
        w_step = (r_cnt < c_STEP) ? r_cnt : c_STEP;
        case (r_kind)
            c_SH_SLL: w_acc_shifted = r_acc << w_step;
            c_SH_SRL: w_acc_shifted = r_acc >> w_step;
            c_SH_SRA: w_acc_shifted = $unsigned($signed(r_acc) >>> w_step);
            default:  w_acc_shifted = r_acc;
        endcase
    end

    // The caller never raises start together with a flush-driven abort, so
    // start is checked first: a capture straight out of DONE can begin the
    // next shift in the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_kind_nxt  = r_kind;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        if (start) begin
            w_state_nxt = c_EX_ST_SHIFT;
            w_kind_nxt  = kind;
            w_acc_nxt   = value;
            w_cnt_nxt   = amt;
        end else if (abort) begin
            w_state_nxt = c_EX_ST_IDLE;
        end else begin
            case (r_state)
                c_EX_ST_IDLE: ;
                c_EX_ST_SHIFT: begin
                    w_acc_nxt = w_acc_shifted;
                    w_cnt_nxt = r_cnt - w_step;
                    if (r_cnt == w_step) w_state_nxt = c_EX_ST_DONE;
                end
                c_EX_ST_DONE: ;
                default: w_state_nxt = c_EX_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_EX_ST_IDLE;
            r_kind  <= c_SH_SLL;
            r_acc   <= 32'd0;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_kind  <= w_kind_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign busy   = (r_state == c_EX_ST_SHIFT);
    assign done   = (r_state == c_EX_ST_DONE);
    assign result = r_acc;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : ex_stage
// Purpose : Execute stage. ID/EX register, one-cycle logic ALU, iterative
//           shifter (via ex_shift_unit) and the combinational result mux that
//           feeds EX/MEM and decode forwarding.
// Ports   : clk, rst (sync, active-low), stall_in, flush,
//           alu_op/alu_sel/id_src1/id_src2/id_des_addr/id_des_exist (decode),
//           ex_des_exist_out/ex_des_addr_out/ex_des_data_out (result),
//           stall_req (shift in progress)
// Revision: 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        flush,
    input  logic [7:0]  alu_op,
    input  logic [2:0]  alu_sel,
    input  logic [31:0] id_src1,
    input  logic [31:0] id_src2,
    input  logic [4:0]  id_des_addr,
    input  logic        id_des_exist,
    output logic        ex_des_exist_out,
    output logic [4:0]  ex_des_addr_out,
    output logic [31:0] ex_des_data_out,
    output logic        stall_req
);

    logic [7:0]  r_alu_op;
    logic [2:0]  r_alu_sel;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [4:0]  r_des_addr;
    logic        r_des_exist;

    logic        w_load;
    logic        w_start;
    logic        w_abort;
    logic        w_busy;
    logic        w_done;
    logic [31:0] w_sh_result;

    assign w_load  = !flush && !stall_in && !w_busy;
    assign w_start = w_load && is_shift_op(alu_op) && (id_src1[4:0] != 5'd0);
    // Capturing any new instruction retires a result held in DONE.
    assign w_abort = flush || w_load;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_alu_op    <= c_EXE_NOP_OP;
            r_alu_sel   <= c_EXE_RES_NOP;
            r_src1      <= 32'd0;
            r_src2      <= 32'd0;
            r_des_addr  <= c_NOP_REG_ADDR;
            r_des_exist <= 1'b0;
        end else if (w_load) begin
            r_alu_op    <= alu_op;
            r_alu_sel   <= alu_sel;
            r_src1      <= id_src1;
            r_src2      <= id_src2;
            r_des_addr  <= id_des_addr;
            r_des_exist <= id_des_exist;
        end
    end

    ex_shift_unit #(
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift (
        .clk    (clk),
        .rst    (rst),
        .start  (w_start),
        .abort  (w_abort),
        .kind   (shift_kind(alu_op)),
        .amt    (id_src1[4:0]),
        .value  (id_src2),
        .busy   (w_busy),
        .done   (w_done),
        .result (w_sh_result)
    );

    always_comb begin
        ex_des_data_out = 32'd0;
        if (r_alu_sel != c_EXE_RES_NOP) begin
            case (r_alu_op)
                c_EXE_OR_OP:  ex_des_data_out = r_src1 | r_src2;
                c_EXE_AND_OP: ex_des_data_out = r_src1 & r_src2;
                c_EXE_XOR_OP: ex_des_data_out = r_src1 ^ r_src2;
                c_EXE_NOR_OP: ex_des_data_out = ~(r_src1 | r_src2);
                // A shift held while the unit is idle had amt==0: pass src2.
                c_EXE_SLL_OP, c_EXE_SRL_OP, c_EXE_SRA_OP:
                    ex_des_data_out = w_busy ? 32'd0 : (w_done ? w_sh_result : r_src2);
                default: ex_des_data_out = 32'd0;
            endcase
        end
    end

    assign ex_des_exist_out = r_des_exist && !w_busy;
    assign ex_des_addr_out  = r_des_addr;
    assign stall_req        = w_busy;

endmodule
`default_nettype wire
